// File: rtl/vga_fb_pkg.sv
// Shared geometry, widths and FSM state type for the framebuffer line-fetch path.
package vga_fb_pkg;

  localparam int V_VIS      = 1080;
  localparam int SCALE_LOG2 = 3;
  localparam int ROW_WORDS  = 240;
  localparam int ROWS       = V_VIS >> SCALE_LOG2;
  localparam int DATA_W     = 12;
  localparam int ADDR_W     = 16;
  localparam int COL_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  // Largest base is 134*240 = 32160, so ADDR_W never wraps.
  function automatic logic [ADDR_W-1:0] row_base(input logic [COL_W-1:0] row);
    return ADDR_W'(row) * ADDR_W'(ROW_WORDS);
  endfunction

endpackage

// File: rtl/rd_return_pipe.sv
// Tracks outstanding RAM reads so each returning word knows its line-buffer bank and column.
module rd_return_pipe
  import vga_fb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_bank,
  input  logic [COL_W-1:0] req_col,
  output logic             ret_valid,
  output logic             ret_bank,
  output logic [COL_W-1:0] ret_col,
  output logic             empty
);

  logic [RD_LAT-1:0] vld_p;
  logic [RD_LAT-1:0] bank_p;
  logic [COL_W-1:0]  col_p [RD_LAT];

  // Valid bits are flushed on reset so no stale read ever reaches the line buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= req_valid;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    bank_p[0] <= req_bank;
    col_p[0]  <= req_col;
    for (int i = 1; i < RD_LAT; i++) begin
      bank_p[i] <= bank_p[i-1];
      col_p[i]  <= col_p[i-1];
    end
  end

  assign ret_valid = vld_p[RD_LAT-1];
  assign ret_bank  = bank_p[RD_LAT-1];
  assign ret_col   = col_p[RD_LAT-1];
  assign empty     = ~|vld_p;

endmodule

// File: rtl/fb_line_fetch_arbiter.sv
// Prefetches one downscaled framebuffer row ahead of the raster into a ping-pong line
// buffer, granting the single RAM port to game-logic writes whenever no reads are issued.
module fb_line_fetch_arbiter
  import vga_fb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic              clk_pix,
  input  logic              rst,
  input  logic              video_on,
  input  logic              vsync,
  input  logic [11:0]       pixel_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [7:0]        lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              fetch_done,
  output logic              overrun
);

  localparam int              R_W      = 12 - SCALE_LOG2;
  localparam logic [R_W-1:0]  LAST_R   = R_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_WORDS - 1);

  state_t           state;
  logic             vsync_q;
  logic             video_on_q;
  logic             bank;
  logic [COL_W-1:0] col;

  logic [R_W-1:0]   r;
  logic             trig0;
  logic             trig_line;
  logic             trig_any;
  logic [COL_W-1:0] trig_row;
  logic             accept;

  logic             ret_valid;
  logic             ret_bank;
  logic [COL_W-1:0] ret_col;
  logic             pipe_empty;

  assign r         = pixel_y[11:SCALE_LOG2];
  assign trig0     = vsync_q & ~vsync;
  assign trig_line = video_on & ~video_on_q & (pixel_y[SCALE_LOG2-1:0] == '0) & (r < LAST_R);
  assign trig_any  = trig0 | trig_line;
  // Frame start outranks a line trigger should both ever coincide.
  assign trig_row  = trig0 ? '0 : COL_W'(r + R_W'(1));

  assign wr_ready  = ((state == IDLE) || (state == DRAIN)) && !trig_any && !rst;
  assign accept    = wr_valid && wr_ready;

  // Edge-detect registers reset to their inactive levels so reset release never fakes a trigger.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vsync_q    <= 1'b0;
      video_on_q <= 1'b1;
      bank       <= 1'b0;
      col        <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fetch_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      video_on_q <= video_on;
      mem_we     <= accept;
      fetch_done <= ret_valid && (ret_col == LAST_COL);
      if (accept) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
      if (trig_any && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (trig_any) begin
            state    <= ISSUE;
            bank     <= trig_row[0];
            col      <= '0;
            mem_re   <= 1'b1;
            mem_addr <= row_base(trig_row);
          end
        end
        ISSUE: begin
          if (col == LAST_COL) begin
            mem_re <= 1'b0;
            state  <= DRAIN;
          end else begin
            col      <= col + COL_W'(1);
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (pipe_empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read return stage: tags issued with mem_re emerge RD_LAT cycles later alongside mem_rdata.
  rd_return_pipe #(
    .RD_LAT(RD_LAT)
  ) u_ret (
    .clk      (clk_pix),
    .rst      (rst),
    .req_valid(mem_re),
    .req_bank (bank),
    .req_col  (col),
    .ret_valid(ret_valid),
    .ret_bank (ret_bank),
    .ret_col  (ret_col),
    .empty    (pipe_empty)
  );

  assign lb_we    = ret_valid;
  assign lb_bank  = ret_valid & ret_bank;
  assign lb_addr  = ret_valid ? ret_col : '0;
  assign lb_wdata = ret_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_line_fetch_arbiter.sv
// Directed bench for fb_line_fetch_arbiter with a two-cycle-latency RAM model.
module tb_fb_line_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        video_on;
  logic        vsync;
  logic [11:0] pixel_y;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [11:0] wr_data;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = '0;
  logic        lb_we;
  logic        lb_bank;
  logic [7:0]  lb_addr;
  logic [11:0] lb_wdata;
  logic        fetch_done;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  logic [15:0] first_we_addr;
  logic [11:0] first_we_data;

  always #5 clk = ~clk;

  fb_line_fetch_arbiter #(.RD_LAT(2)) dut (
    .clk_pix   (clk),
    .rst       (rst),
    .video_on  (video_on),
    .vsync     (vsync),
    .pixel_y   (pixel_y),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .lb_we     (lb_we),
    .lb_bank   (lb_bank),
    .lb_addr   (lb_addr),
    .lb_wdata  (lb_wdata),
    .fetch_done(fetch_done),
    .overrun   (overrun)
  );

  function automatic logic [11:0] exp_data(input int a);
    return 12'(a * 5 + 3 + (a >> 8));
  endfunction

  // RAM model: data for a read issued in cycle k is presented in cycle k+2.
  logic [11:0] ram [0:65535];
  logic        rd_v1 = 1'b0;
  logic [15:0] rd_a1 = '0;
  initial for (int a = 0; a < 65536; a++) ram[a] = exp_data(a);
  always @(posedge clk) begin
    rd_v1     <= mem_re;
    rd_a1     <= mem_addr;
    mem_rdata <= rd_v1 ? ram[rd_a1] : 12'hFFF;
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic video_rise(input int y);
    video_on = 1'b0;
    @(negedge clk);
    video_on = 1'b1;
    pixel_y  = 12'(y);
  endtask

  // Called during the trigger cycle; observes cycles 1..250 after it.
  task automatic run_fetch(input string tag, input int row, input int bank, input bit expect_fetch,
                           input int inj, input int exp_first_we);
    int re_cnt = 0, re_bad = 0, lb_cnt = 0, lb_bad = 0;
    int done_cnt = 0, done_cyc = 0, rdy_issue = 0, rdy_drain = 0;
    int first_we = 0, overlap = 0;
    first_we_addr = '0;
    first_we_data = '0;
    for (int c = 1; c <= 250; c++) begin
      @(negedge clk);
      if (mem_re) begin
        if (mem_addr != 16'(row * 240 + re_cnt) || c != re_cnt + 1) re_bad++;
        re_cnt++;
      end
      if (lb_we) begin
        if (lb_bank != bank[0] || lb_addr != 8'(lb_cnt) || c != lb_cnt + 3 ||
            lb_wdata != exp_data(row * 240 + lb_cnt)) lb_bad++;
        lb_cnt++;
      end
      if (fetch_done) begin
        if (done_cnt == 0) done_cyc = c;
        done_cnt++;
      end
      if (wr_ready && c <= 240) rdy_issue++;
      if (wr_ready && c >= 241 && c <= 243) rdy_drain++;
      if (mem_we && first_we == 0) begin
        first_we      = c;
        first_we_addr = mem_addr;
        first_we_data = mem_wdata;
      end
      if (mem_re && mem_we) overlap++;
      if (inj > 0 && c == inj) video_on = 1'b0;
      if (inj > 0 && c == inj + 1) begin
        video_on = 1'b1;
        pixel_y  = 12'd16;
      end
    end
    chk({tag, "_re_cnt"},    re_cnt,    expect_fetch ? 240 : 0);
    chk({tag, "_re_seq"},    re_bad,    0);
    chk({tag, "_lb_cnt"},    lb_cnt,    expect_fetch ? 240 : 0);
    chk({tag, "_lb_bad"},    lb_bad,    0);
    chk({tag, "_done_cnt"},  done_cnt,  expect_fetch ? 1 : 0);
    chk({tag, "_done_cyc"},  done_cyc,  expect_fetch ? 243 : 0);
    chk({tag, "_rdy_issue"}, rdy_issue, expect_fetch ? 0 : 240);
    chk({tag, "_rdy_drain"}, rdy_drain, 3);
    chk({tag, "_first_we"},  first_we,  exp_first_we);
    chk({tag, "_re_we_both"}, overlap,  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    rst = 1'b1; vsync = 1'b1; video_on = 1'b0; pixel_y = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {mem_re, mem_we, lb_we, lb_bank, fetch_done, overrun, wr_ready}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_lb_addr", lb_addr, 0);
    chk("rst_lb_wdata", lb_wdata, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("idle_wr_ready", wr_ready, 1);

    // Frame start: row 0 into bank 0.
    vsync = 1'b0;
    run_fetch("vs_row0", 0, 0, 1, 0, 0);
    vsync = 1'b1;

    // Line triggers.
    video_rise(0);    run_fetch("vo_y0",    1, 1, 1, 0, 0);
    video_rise(8);    run_fetch("vo_y8",    2, 0, 1, 0, 0);
    video_rise(3);    run_fetch("vo_y3",    0, 0, 0, 0, 0);
    video_rise(1072); run_fetch("vo_y1072", 0, 0, 0, 0, 0);

    // Held write: accepted in IDLE, stalled through ISSUE, resumes in DRAIN.
    wr_valid = 1'b1; wr_addr = 16'hF000; wr_data = 12'hABC;
    #1 chk("wr_idle_ready", wr_ready, 1);
    @(negedge clk);
    chk("wr_idle_mem_we", mem_we, 1);
    chk("wr_idle_addr", mem_addr, 16'hF000);
    chk("wr_idle_data", mem_wdata, 12'hABC);
    video_rise(16);
    #1 chk("wr_trig_ready", wr_ready, 0);
    run_fetch("wr_held", 3, 1, 1, 0, 242);
    chk("wr_held_addr", first_we_addr, 16'hF000);
    chk("wr_held_data", first_we_data, 12'hABC);
    wr_valid = 1'b0;

    // Write and trigger in the same IDLE cycle.
    @(negedge clk);
    vsync = 1'b0; wr_valid = 1'b1; wr_addr = 16'hF001; wr_data = 12'h123;
    #1 chk("same_cyc_ready", wr_ready, 0);
    run_fetch("same_cyc", 0, 0, 1, 0, 242);
    chk("same_cyc_addr", first_we_addr, 16'hF001);
    chk("same_cyc_data", first_we_data, 12'h123);
    wr_valid = 1'b0; vsync = 1'b1;

    // Line trigger forced during ISSUE.
    @(negedge clk);
    chk("ovr_before", overrun, 0);
    vsync = 1'b0;
    run_fetch("ovr", 0, 0, 1, 100, 0);
    chk("ovr_set", overrun, 1);
    repeat (5) @(negedge clk);
    chk("ovr_sticky", overrun, 1);
    vsync = 1'b1;

    // Reset in the middle of ISSUE.
    @(negedge clk);
    vsync = 1'b0;
    repeat (101) @(negedge clk);
    chk("mid_re", mem_re, 1);
    chk("mid_addr", mem_addr, 100);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_flags", {mem_re, mem_we, lb_we, lb_bank, fetch_done, overrun, wr_ready}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_lb_addr", lb_addr, 0);
    rst = 1'b0;
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_re || lb_we || fetch_done) busy++;
    end
    chk("post_rst_quiet", busy, 0);
    chk("post_rst_ready", wr_ready, 1);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    run_fetch("restart", 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
